// File: rtl/regfile_tagged.sv
// Tagged architectural register file with post-reset zeroing sweep.
// Optional same-cycle commit bypass on read ports: REGFILE_BYPASS_EN.
module regfile_tagged #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int TAG_W = 4,
    parameter int NREAD = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ready,
    input  logic [NREAD-1:0]       rd_en,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*WIDTH-1:0] rd_data,
    output logic [NREAD-1:0]       rd_busy,
    output logic [NREAD*TAG_W-1:0] rd_tag,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    input  logic [TAG_W-1:0]       iss_tag,
    input  logic                   cmt_en,
    input  logic [AW-1:0]          cmt_addr,
    input  logic [TAG_W-1:0]       cmt_tag,
    input  logic [WIDTH-1:0]       cmt_data,
    input  logic                   flush
);

    typedef enum logic {INIT, RUN} state_t;

    state_t state, state_n;
    logic [AW-1:0] cnt, cnt_n;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [DEPTH-1:0] busy_q;

    logic run, init, cmt_wr, cmt_clr, iss_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            INIT: begin
                cnt_n = cnt + 1'b1;
                if (cnt == AW'(DEPTH - 1)) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            end
            RUN: state_n = RUN;
            default: state_n = INIT;
        endcase
    end

    assign ready = (state == RUN);
    assign run   = ready && !rst;
    assign init  = (state == INIT);

    // A commit only retires the entry if no younger producer renamed it.
    assign cmt_wr  = cmt_en && (cmt_addr != '0);
    assign cmt_clr = cmt_wr && busy_q[cmt_addr] && (tag_q[cmt_addr] == cmt_tag);
    assign iss_wr  = iss_en && (iss_addr != '0) && !flush;

    always_ff @(posedge clk) begin
        if (init) begin
            mem[cnt] <= '0;
        end else if (run && cmt_wr) begin
            mem[cmt_addr] <= cmt_data;
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            busy_q[cnt] <= 1'b0;
            tag_q[cnt]  <= '0;
        end else if (run) begin
            if (flush) begin
                busy_q <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    tag_q[i] <= '0;
                end
            end else begin
                if (cmt_clr) begin
                    busy_q[cmt_addr] <= 1'b0;
                    tag_q[cmt_addr]  <= '0;
                end
                // Issue after commit so a same-entry issue wins.
                if (iss_wr) begin
                    busy_q[iss_addr] <= 1'b1;
                    tag_q[iss_addr]  <= iss_tag;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_tag  = '0;
        for (int i = 0; i < NREAD; i++) begin
            logic [AW-1:0] a;
            a = rd_addr[i*AW +: AW];
            if (ready && rd_en[i] && (a != '0)) begin
                rd_data[i*WIDTH +: WIDTH] = mem[a];
                rd_busy[i]                = busy_q[a];
                rd_tag[i*TAG_W +: TAG_W]  = tag_q[a];
`ifdef REGFILE_BYPASS_EN
                if (cmt_wr && (cmt_addr == a)) begin
                    rd_data[i*WIDTH +: WIDTH] = cmt_data;
                    if (cmt_clr) begin
                        rd_busy[i]               = 1'b0;
                        rd_tag[i*TAG_W +: TAG_W] = '0;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_tagged.sv
// Directed testbench for regfile_tagged (default parameters).
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_tagged;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int TAG_W = 4;
    localparam int NREAD = 2;
    localparam int AW = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   ready;
    logic [NREAD-1:0]       rd_en;
    logic [NREAD*AW-1:0]    rd_addr;
    logic [NREAD*WIDTH-1:0] rd_data;
    logic [NREAD-1:0]       rd_busy;
    logic [NREAD*TAG_W-1:0] rd_tag;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;
    logic [TAG_W-1:0]       iss_tag;
    logic                   cmt_en;
    logic [AW-1:0]          cmt_addr;
    logic [TAG_W-1:0]       cmt_tag;
    logic [WIDTH-1:0]       cmt_data;
    logic                   flush;

    int vectors = 0;
    int errors = 0;

    regfile_tagged #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W), .NREAD(NREAD)
    ) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .rd_tag(rd_tag),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_tag(iss_tag),
        .cmt_en(cmt_en), .cmt_addr(cmt_addr), .cmt_tag(cmt_tag),
        .cmt_data(cmt_data), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
        #1;
    endtask

    function automatic logic [WIDTH-1:0] dat(input int p);
        return rd_data[p*WIDTH +: WIDTH];
    endfunction

    function automatic logic [TAG_W-1:0] tg(input int p);
        return rd_tag[p*TAG_W +: TAG_W];
    endfunction

    task automatic chk_port(input string name, input int p,
                            input logic [WIDTH-1:0] d, input logic b,
                            input logic [TAG_W-1:0] t);
        check({name, ".data"}, 64'(dat(p)), 64'(d));
        check({name, ".busy"}, 64'(rd_busy[p]), 64'(b));
        check({name, ".tag"}, 64'(tg(p)), 64'(t));
    endtask

    task automatic idle();
        iss_en = 1'b0;
        cmt_en = 1'b0;
        flush  = 1'b0;
    endtask

    initial begin
        logic byp;
`ifdef REGFILE_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        rst = 1'b1;
        rd_en = '0;
        rd_addr = '0;
        iss_addr = '0;
        iss_tag = '0;
        cmt_addr = '0;
        cmt_tag = '0;
        cmt_data = '0;
        idle();

        tick();
        tick();
        check("reset.ready", 64'(ready), 64'd0);
        rd(0, 5'd5);
        rd(1, 5'd31);
        chk_port("reset.p0", 0, '0, 1'b0, '0);

        rst = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) tick();
        check("init.ready_31", 64'(ready), 64'd0);
        chk_port("init.p1", 1, '0, 1'b0, '0);
        tick();
        check("init.ready_32", 64'(ready), 64'd1);
        rd(0, 5'd5);
        chk_port("swept.r5", 0, '0, 1'b0, '0);

        // Tag match.
        iss_en = 1'b1; iss_addr = 5'd5; iss_tag = 4'd3;
        tick();
        idle();
        rd(0, 5'd5);
        chk_port("iss.r5", 0, '0, 1'b1, 4'd3);
        cmt_en = 1'b1; cmt_addr = 5'd5; cmt_tag = 4'd3; cmt_data = 32'hDEADBEEF;
        tick();
        idle();
        rd(1, 5'd5);
        chk_port("match.r5", 1, 32'hDEADBEEF, 1'b0, '0);

        // Tag mismatch.
        iss_en = 1'b1; iss_addr = 5'd5; iss_tag = 4'd3;
        tick();
        iss_tag = 4'd7;
        tick();
        idle();
        cmt_en = 1'b1; cmt_addr = 5'd5; cmt_tag = 4'd3; cmt_data = 32'h11;
        tick();
        idle();
        chk_port("mismatch.r5", 1, 32'h11, 1'b1, 4'd7);

        // Same-cycle issue and commit.
        iss_en = 1'b1; iss_addr = 5'd7; iss_tag = 4'd9;
        cmt_en = 1'b1; cmt_addr = 5'd7; cmt_tag = 4'd2; cmt_data = 32'h22;
        tick();
        idle();
        rd(0, 5'd7);
        chk_port("isscmt.r7", 0, 32'h22, 1'b1, 4'd9);

        // Flush.
        iss_en = 1'b1;
        iss_addr = 5'd1; iss_tag = 4'd1; tick();
        iss_addr = 5'd2; iss_tag = 4'd2; tick();
        iss_addr = 5'd3; iss_tag = 4'd3; tick();
        idle();
        rd(0, 5'd3);
        chk_port("pre_flush.r3", 0, '0, 1'b1, 4'd3);
        flush = 1'b1;
        iss_en = 1'b1; iss_addr = 5'd4; iss_tag = 4'd1;
        cmt_en = 1'b1; cmt_addr = 5'd6; cmt_tag = 4'd0; cmt_data = 32'h66;
        tick();
        idle();
        rd(0, 5'd1); rd(1, 5'd2);
        check("flush.r1.busy", 64'(rd_busy[0]), 64'd0);
        check("flush.r2.busy", 64'(rd_busy[1]), 64'd0);
        rd(0, 5'd3); rd(1, 5'd4);
        chk_port("flush.r3", 0, '0, 1'b0, '0);
        chk_port("flush.r4", 1, '0, 1'b0, '0);
        rd(0, 5'd5); rd(1, 5'd6);
        chk_port("flush.r5", 0, 32'h11, 1'b0, '0);
        chk_port("flush.r6", 1, 32'h66, 1'b0, '0);

        // Same-cycle read of a commit.
        cmt_en = 1'b1; cmt_addr = 5'd9; cmt_tag = 4'd0; cmt_data = 32'h55;
        rd(0, 5'd9);
        check("byp.r9.data", 64'(dat(0)), byp ? 64'h55 : 64'h0);
        tick();
        idle();
        rd(0, 5'd9);
        check("after.r9.data", 64'(dat(0)), 64'h55);

        iss_en = 1'b1; iss_addr = 5'd10; iss_tag = 4'd4;
        tick();
        idle();
        cmt_en = 1'b1; cmt_addr = 5'd10; cmt_tag = 4'd4; cmt_data = 32'hAA;
        rd(1, 5'd10);
        chk_port("byp.r10", 1, byp ? 32'hAA : 32'h0, !byp, byp ? 4'd0 : 4'd4);
        tick();
        idle();
        chk_port("after.r10", 1, 32'hAA, 1'b0, '0);

        // Register 0 and disabled port.
        cmt_en = 1'b1; cmt_addr = 5'd0; cmt_tag = 4'd0; cmt_data = 32'h77;
        iss_en = 1'b1; iss_addr = 5'd0; iss_tag = 4'd5;
        rd(0, 5'd0);
        chk_port("r0.same", 0, '0, 1'b0, '0);
        tick();
        idle();
        chk_port("r0.after", 0, '0, 1'b0, '0);
        rd(1, 5'd7);
        rd_en[1] = 1'b0;
        #1;
        chk_port("rden0.r7", 1, '0, 1'b0, '0);

        // Mid-operation reset re-sweeps the array.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rerst.ready", 64'(ready), 64'd0);
        rd(0, 5'd5);
        check("rerst.r5.data", 64'(dat(0)), 64'h0);
        for (int i = 0; i < DEPTH; i++) tick();
        check("rerst.ready_32", 64'(ready), 64'd1);
        rd(0, 5'd5); rd(1, 5'd7);
        chk_port("rerst.r5", 0, '0, 1'b0, '0);
        chk_port("rerst.r7", 1, '0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/regfile_tagged.md
# regfile_tagged

Parametrised multi-read-port architectural register file with per-register rename tags, for the out-of-order EPU core. It sits between decode/issue and the reorder-buffer commit stage. Issue marks a destination register busy with a producer tag. Commit writes the result and clears the busy bit only if the tag still matches. A post-reset sweep FSM zeroes the array one entry per cycle, so the storage can map to RAM without a reset net.

## Interface
- WIDTH, 32, data width of each register
- DEPTH, 32, number of registers (power of two, ≥2); AW = $clog2(DEPTH) derived
- TAG_W, 4, rename tag width
- NREAD, 2, number of independent read ports

- clk  in  1  single clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- ready  out  1  high once the init sweep is complete
- rd_en  in  NREAD  per-port read enable
- rd_addr  in  NREAD*AW  port i at [i*AW +: AW]
- rd_data  out  NREAD*WIDTH  port i at [i*WIDTH +: WIDTH]
- rd_busy  out  NREAD  register has a pending producer
- rd_tag  out  NREAD*TAG_W  pending producer tag; 0 when not busy
- iss_en  in  1  mark iss_addr busy
- iss_addr  in  AW  destination register being renamed
- iss_tag  in  TAG_W  producer tag
- cmt_en  in  1  commit write
- cmt_addr  in  AW  register written
- cmt_tag  in  TAG_W  tag of committing producer
- cmt_data  in  WIDTH  committed value
- flush  in  1  clear all busy bits (pipeline squash)

## Operation
- FSM states: INIT and RUN.
  - rst forces INIT with sweep counter = 0, including mid-operation.
- INIT:
  - Each cycle writes data 0, busy 0, tag 0 to entry [counter], then increments the counter.
  - After entry DEPTH-1 is written, moves to RUN.
  - iss_en, cmt_en and flush are ignored.
  - All rd_data, rd_busy and rd_tag outputs are 0.
- RUN, read ports (combinational):
  - rd_en=0 gives zeros on rd_data, rd_busy and rd_tag.
  - Address 0 always reads data 0, busy 0, tag 0.
  - Otherwise the port returns the stored data, busy bit and tag.
- RUN, commit (cmt_en, addr≠0):
  - Data is always written (commits arrive in program order).
  - busy is cleared and tag set to 0 only if busy=1 and stored tag == cmt_tag.
  - On tag mismatch the busy bit and tag are kept, because a younger producer is pending.
- RUN, issue (iss_en, addr≠0):
  - Sets busy=1 and tag=iss_tag.
- Simultaneous iss and cmt to the same address: data is written, and the entry ends busy with iss_tag (issue wins).
- flush:
  - Clears every busy bit and tag.
  - A same-cycle iss_en is discarded.
  - A same-cycle cmt_en still writes its data.
- Writes and issues to address 0 are dropped.

## Timing
- Reset values: ready=0, state=INIT, all read outputs 0.
- After rst deasserts, INIT lasts exactly DEPTH cycles; ready rises on the following clock edge and stays high until the next rst.
- Reads have zero latency.
- Commit, issue and flush effects are registered: visible the cycle after the edge (see bypass below).
- NREAD read ports are fully independent; any ports may read the same address.

## Configuration
- REGFILE_BYPASS_EN defined: a read port whose address equals cmt_addr, with cmt_en=1 in RUN and address≠0, returns the current cycle's commit, combinationally:
  - rd_data = cmt_data.
  - rd_busy = 0 and rd_tag = 0 if that commit clears the entry.
  - Otherwise the stored busy bit and tag.
  - Issue and flush are never bypassed.
- REGFILE_BYPASS_EN undefined: read ports show stored state only, so a commit is visible one cycle later.

## Test plan
- Reset and init: rst high for 2 cycles, then low → ready=0 for exactly 32 cycles, then 1. Reads of any address during INIT return 0.
- Tag match: iss r5 tag 3, then cmt r5 tag 3 data 0xDEADBEEF → next cycle r5 reads 0xDEADBEEF, busy 0, tag 0.
- Tag mismatch: iss r5 tag 3, iss r5 tag 7, cmt r5 tag 3 data 0x11 → r5 reads 0x11, busy 1, tag 7.
- Same-cycle iss tag 9 and cmt tag 2 (data 0x22) on r7 → r7 reads 0x22, busy 1, tag 9.
- Flush: r1, r2 and r3 busy; flush together with iss r4 tag 1 → all busy bits 0, r4 not busy.
- Bypass: with REGFILE_BYPASS_EN, cmt r9 data 0x55 while reading r9 → same-cycle rd_data=0x55. Without the macro, the same-cycle read shows the old value and 0x55 appears next cycle. Writes to r0 always read back 0.
